// File: rtl/arb_mux_pkg.sv
// Shared constants and the index-width helper for the arb_mux_n channel multiplexer.
package arb_mux_pkg;

    localparam int unsigned ARB_WIDTH_DEF  = 16;
    localparam int unsigned ARB_NUM_IN_DEF = 2;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned p;
        r = 0;
        p = 1;
        while (p < v) begin
            p = p << 1;
            r = r + 1;
        end
        return r;
    endfunction

    // A one-bit index is kept even when clog2 would give zero.
    function automatic int unsigned sel_width(input int unsigned n);
        return (clog2(n) > 1) ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arb_mux_grant.sv
// Grant selection for arb_mux_n: fixed lowest-index priority, or round-robin with a
// rotating pointer when ARB_MUX_RR_EN is defined.
module arb_mux_grant
    import arb_mux_pkg::*;
#(
    parameter int unsigned NUM_IN = ARB_NUM_IN_DEF,
    parameter int unsigned SEL_W  = sel_width(ARB_NUM_IN_DEF)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NUM_IN-1:0] valid_i,
    input  logic              advance_i,
    output logic [NUM_IN-1:0] grant_o,
    output logic [SEL_W-1:0]  grant_idx_o,
    output logic              any_o
);

    logic [NUM_IN-1:0] cand;
    logic              found;

`ifdef ARB_MUX_RR_EN
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [NUM_IN-1:0] upper;

    // Wrapping search: prefer valid indices at or above the pointer, else fall back to
    // the lowest valid index, which is the first one reached after wrapping past NUM_IN-1.
    always_comb begin
        for (int unsigned j = 0; j < NUM_IN; j++) begin
            upper[j] = valid_i[j] && (j >= 32'(ptr_q));
        end
        cand = (|upper) ? upper : valid_i;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i) begin
            if (32'(grant_idx_o) == NUM_IN - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx_o + SEL_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    logic unused_ok;

    assign cand      = valid_i;
    assign unused_ok = &{1'b0, clk_i, rst_ni, advance_i};
`endif

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        for (int unsigned j = 0; j < NUM_IN; j++) begin
            if (!found && cand[j]) begin
                found       = 1'b1;
                grant_o[j]  = 1'b1;
                grant_idx_o = SEL_W'(j);
            end
        end
    end

    assign any_o = |valid_i;

endmodule

// File: rtl/arb_mux_n.sv
// N-to-1 valid/ready channel multiplexer with a registered output stage.
// Define ARB_MUX_RR_EN for round-robin arbitration instead of fixed priority.
module arb_mux_n
    import arb_mux_pkg::*;
#(
    parameter  int unsigned WIDTH  = ARB_WIDTH_DEF,
    parameter  int unsigned NUM_IN = ARB_NUM_IN_DEF,
    localparam int unsigned SEL_W  = sel_width(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic [SEL_W-1:0]  out_sel_q, out_sel_d;
    logic              out_valid_q, out_valid_d;

    logic              load_en;
    logic              any_valid;
    logic              advance;
    logic [NUM_IN-1:0] grant;
    logic [SEL_W-1:0]  grant_idx;
    logic [WIDTH-1:0]  mux_data;

    arb_mux_grant #(
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_grant (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .valid_i     (in_valid),
        .advance_i   (advance),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .any_o       (any_valid)
    );

    assign load_en = !out_valid_q || out_ready;

    // Reset clears out_valid, which alone would raise load_en, so rst_n gates ready too.
    assign in_ready = rst_n ? (grant & {NUM_IN{load_en}}) : '0;
    assign advance  = rst_n && load_en && any_valid;

    always_comb begin
        mux_data = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (grant[i]) begin
                mux_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        if (load_en) begin
            out_valid_d = any_valid;
            if (any_valid) begin
                out_data_d = mux_data;
                out_sel_d  = grant_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_arb_mux_n.sv
// Scoreboard bench for arb_mux_n (WIDTH=16, NUM_IN=4); expectations follow ARB_MUX_RR_EN.
module tb_arb_mux_n;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned NUM_IN = 4;
`ifdef ARB_MUX_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    typedef struct {
        logic [15:0] d;
        logic [1:0]  s;
    } exp_t;

    logic                    clk;
    logic                    rst_n;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [NUM_IN-1:0]       in_valid;
    logic [NUM_IN-1:0]       in_ready;
    logic [WIDTH-1:0]        out_data;
    logic [1:0]              out_sel;
    logic                    out_valid;
    logic                    out_ready;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    arb_mux_n #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ch_data(input int s);
        case (s)
            0:       return 16'hC0C0;
            1:       return 16'hB1B1;
            2:       return 16'h00A5;
            default: return 16'hD3D3;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int s);
        exp_t e;
        e.d = ch_data(s);
        e.s = 2'(s);
        exp_q.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: each negedge with out_valid & out_ready is one word leaving the DUT.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_word: got data %0h sel %0d expected none", out_data, out_sel);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("mon_data", 32'(out_data), 32'(e.d));
                chk("mon_sel", 32'(out_sel), 32'(e.s));
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] stall_pat [3];
        int         s;
        stall_pat[0] = 4'b1010;
        stall_pat[1] = 4'b0101;
        stall_pat[2] = 4'b1111;

        rst_n     = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        in_data   = {$urandom, $urandom};
        #1 rst_n  = 1'b0;
        #2;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'h0000);
        chk("rst_sel", 32'(out_sel), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'h0);
        out_ready = 1'b1;
        #9;
        chk("rst_ready_clk", 32'(in_ready), 32'h0);
        chk("rst_valid_clk", 32'(out_valid), 32'd0);

        in_data = {ch_data(3), ch_data(2), ch_data(1), ch_data(0)};
        @(negedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 4'b0100;
        #1 chk("ready_ch2", 32'(in_ready), 32'b0100);
        push(2);
        next_cycle();
        chk("first_valid", 32'(out_valid), 32'd1);
        chk("first_data", 32'(out_data), 32'h00A5);
        chk("first_sel", 32'(out_sel), 32'd2);

        in_valid = 4'b0000;
        #1 chk("idle_ready", 32'(in_ready), 32'h0);
        next_cycle();
        chk("idle_valid", 32'(out_valid), 32'd0);
        chk("idle_hold", 32'(out_data), 32'h00A5);

        in_valid = 4'b0001;
        #1 chk("ready_ch0", 32'(in_ready), 32'b0001);
        push(0);
        next_cycle();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = stall_pat[i];
            #1;
            chk("stall_ready", 32'(in_ready), 32'h0);
            chk("stall_data", 32'(out_data), 32'hC0C0);
            chk("stall_valid", 32'(out_valid), 32'd1);
            next_cycle();
        end
        out_ready = 1'b1;
        in_valid  = 4'b0010;
        #1 chk("release_ready", 32'(in_ready), 32'b0010);
        push(1);
        next_cycle();
        chk("release_sel", 32'(out_sel), 32'd1);

        // Load ch2 (advancing any round-robin pointer), then reset while it is held.
        in_valid = 4'b0100;
        #1 chk("held_ready", 32'(in_ready), 32'b0100);
        next_cycle();
        out_ready = 1'b0;
        in_valid  = 4'b1111;
        #1;
        chk("held_valid", 32'(out_valid), 32'd1);
        chk("held_data", 32'(out_data), 32'h00A5);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_data", 32'(out_data), 32'h0);
        chk("midrst_sel", 32'(out_sel), 32'd0);
        chk("midrst_ready", 32'(in_ready), 32'h0);
        in_valid = 4'b0000;
        #1 rst_n = 1'b1;
        next_cycle();
        chk("postrst_valid", 32'(out_valid), 32'd0);

        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            s        = RR ? k : 0;
            in_valid = 4'b1111;
            #1 chk("all_ready", 32'(in_ready), 32'(1 << s));
            push(s);
            next_cycle();
            chk("all_valid", 32'(out_valid), 32'd1);
        end
        for (int k = 0; k < 4; k++) begin
            s        = (RR && (k % 2 == 1)) ? 3 : 0;
            in_valid = 4'b1001;
            #1 chk("edge_ready", 32'(in_ready), 32'(1 << s));
            push(s);
            next_cycle();
            chk("edge_valid", 32'(out_valid), 32'd1);
        end

        in_valid = 4'b0000;
        next_cycle();
        next_cycle();
        chk("drain_valid", 32'(out_valid), 32'd0);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
